uart_tx: RTL and testbench

- UART transmit engine; the stage directly downstream of the UART register block.
- Consumes start_tx, send_data, bit_count_sel and baud_rate_sel from the register block and drives the serial tx line.
- Returns transmitter busy and data-sent status to the register block's status logic (w_transmistter_busy, w_data_sent).
- Frame format: 1 start bit, 5-8 data bits LSB first, STOP_BITS stop bits, no parity.

---
 rtl/uart_pkg.sv | 70 +++++++
 rtl/uart_tx_if.sv | 25 ++
 rtl/uart_baud_gen.sv | 39 +++
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud table, divisor and bit-count decode, tx FSM states, register map.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: tx_state_t, REG_* addresses, baud_of(), calc_div(), cnt_width(), decode_bits().
package uart_pkg;

  // Transmit FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Register block address map (byte offsets), shared with the register block.
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_TXDATA = 4'h8;
  localparam logic [3:0] REG_CFG    = 4'hC;

  // Baud rate selected by baud_rate_sel.
  function automatic int baud_of(input logic [2:0] sel);
    int b;
    case (sel)
      3'd0:    b = 9600;
      3'd1:    b = 19200;
      3'd2:    b = 38400;
      3'd3:    b = 57600;
      3'd4:    b = 115200;
      3'd5:    b = 230400;
      3'd6:    b = 460800;
      default: b = 921600;
    endcase
    return b;
  endfunction

  // Clocks per bit, rounded to nearest, never below 1 (fast rates on slow clocks).
  function automatic int calc_div(input int clk_freq, input logic [2:0] sel);
    int b;
    int d;
    b = baud_of(sel);
    d = (clk_freq + b / 2) / b;
    return (d < 1) ? 1 : d;
  endfunction

  // Baud counter width: enough for the largest divisor, minimum 1 bit.
  function automatic int cnt_width(input int clk_freq);
    int m;
    int w;
    m = 1;
    for (int s = 0; s < 8; s++) begin
      if (calc_div(clk_freq, 3'(s)) > m) m = calc_div(clk_freq, 3'(s));
    end
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  // Data bits per frame: 0..3 -> 5..8, anything above saturates at 8.
  function automatic logic [3:0] decode_bits(input logic [2:0] sel);
    logic [3:0] n;
    case (sel)
      3'd0:    n = 4'd5;
      3'd1:    n = 4'd6;
      3'd2:    n = 4'd7;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Register block <-> uart_tx connection bundle.
// Latency: n/a (wiring only).
// Backpressure: none; start_tx is a level, busy/data_sent report progress back.
// master = register block side, slave = transmit engine side.
interface uart_tx_if
  import uart_pkg::*;
;
  logic       start_tx;
  logic [7:0] send_data;
  logic [2:0] bit_count_sel;
  logic [2:0] baud_rate_sel;
  logic       tx;
  logic       busy;
  logic       data_sent;

  modport master (
    output start_tx, send_data, bit_count_sel, baud_rate_sel,
    input  tx, busy, data_sent
  );

  modport slave (
    input  start_tx, send_data, bit_count_sel, baud_rate_sel,
    output tx, busy, data_sent
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Loadable down-counter emitting bit_tick once every (reload+1) enabled cycles.
// Latency: first tick reload+1 cycles after load; then every reload+1 cycles.
// Backpressure: none; load restarts the period immediately, en freezes counting.
// Ports: clk, rst, load (restart + capture reload), en, reload (divisor-1), bit_tick.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] reload,
  output logic             bit_tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload_q;

  assign bit_tick = en && (cnt == '0);

  // The period is captured at load so the caller may change reload mid-frame;
  // each tick reloads from it, so bit boundaries never drift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      reload_q <= '0;
    end else if (load) begin
      cnt      <= reload;
      reload_q <= reload;
    end else if (bit_tick) begin
      cnt <= reload_q;
    end else if (en) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: 1 start bit, 5-8 data bits LSB first, STOP_BITS stop bits, no parity.
// Latency: tx falls one clock after start is accepted; busy lasts (1+N+STOP_BITS)*DIV cycles.
// Backpressure: start_tx is a level; one frame per low->high, ignored until seen low again.
// Ports: clk, rst (async, active-high), bus (slave: start_tx/send_data/bit_count_sel/
//        baud_rate_sel in; tx/busy/data_sent out).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int STOP_BITS = 1
) (
  input logic       clk,
  input logic       rst,
  uart_tx_if.slave  bus
);

  localparam int CNT_W = cnt_width(CLK_FREQ);

  tx_state_t  state, state_nxt;
  logic       armed, armed_nxt;
  logic [7:0] data_q, data_nxt;
  logic [3:0] nbits_q, nbits_nxt;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic       stop_idx, stop_idx_nxt;
  logic       tx_q, tx_nxt;
  logic       busy_q, busy_nxt;
  logic       sent_q, sent_nxt;
  logic       start_go;
  logic       bit_tick;

  // Per-rate divisor-1 table, fixed at elaboration.
  logic [CNT_W-1:0] div_tab [8];
  for (genvar g = 0; g < 8; g++) begin : g_div
    assign div_tab[g] = CNT_W'(calc_div(CLK_FREQ, 3'(g)) - 1);
  end

  assign start_go = (state == ST_IDLE) && armed && bus.start_tx;

  uart_baud_gen #(.CNT_W(CNT_W)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .load     (start_go),
    .en       (state != ST_IDLE),
    .reload   (div_tab[bus.baud_rate_sel]),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_nxt    = state;
    armed_nxt    = armed;
    data_nxt     = data_q;
    nbits_nxt    = nbits_q;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    tx_nxt       = tx_q;
    busy_nxt     = busy_q;
    sent_nxt     = 1'b0;

    // Seeing start_tx low re-arms; a held-high request never sends twice.
    if (!bus.start_tx) armed_nxt = 1'b1;

    case (state)
      ST_IDLE: begin
        if (start_go) begin
          state_nxt    = ST_START;
          armed_nxt    = 1'b0;
          data_nxt     = bus.send_data;
          nbits_nxt    = decode_bits(bus.bit_count_sel);
          bit_idx_nxt  = '0;
          stop_idx_nxt = 1'b0;
          tx_nxt       = 1'b0;
          busy_nxt     = 1'b1;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_nxt = ST_DATA;
          tx_nxt    = data_q[0];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if ({1'b0, bit_idx} == nbits_q - 4'd1) begin
            state_nxt = ST_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = data_q[bit_idx_nxt];
          end
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            sent_nxt  = 1'b1;
          end else begin
            stop_idx_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      armed    <= 1'b0;
      data_q   <= '0;
      nbits_q  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      armed    <= armed_nxt;
      data_q   <= data_nxt;
      nbits_q  <= nbits_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
      tx_q     <= tx_nxt;
      busy_q   <= busy_nxt;
      sent_q   <= sent_nxt;
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.data_sent = sent_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances at 96 kHz (STOP_BITS 1 and 2) against a per-cycle frame model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx;

  localparam int F = 96000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_if if1 ();
  uart_tx_if if2 ();

  uart_tx #(.CLK_FREQ(F), .STOP_BITS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_tx #(.CLK_FREQ(F), .STOP_BITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- reference model: rates, bit counts, and the line level at cycle j of a frame ----
  function automatic int exp_div(input int sel);
    int b;
    int d;
    case (sel)
      0: b = 9600;
      1: b = 19200;
      2: b = 38400;
      3: b = 57600;
      4: b = 115200;
      5: b = 230400;
      6: b = 460800;
      default: b = 921600;
    endcase
    d = (2 * F + b) / (2 * b);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int exp_n(input int sel);
    return (sel < 4) ? 5 + sel : 8;
  endfunction

  function automatic logic exp_tx(input logic [7:0] d, input int n, input int div, input int j);
    int slot;
    slot = j / div;
    if (slot == 0) return 1'b0;
    if (slot <= n) return d[slot-1];
    return 1'b1;
  endfunction

  // ---- per-instance access ----
  function automatic logic o_tx(input int w);
    return (w == 2) ? if2.tx : if1.tx;
  endfunction
  function automatic logic o_busy(input int w);
    return (w == 2) ? if2.busy : if1.busy;
  endfunction
  function automatic logic o_sent(input int w);
    return (w == 2) ? if2.data_sent : if1.data_sent;
  endfunction

  task automatic set_start(input int w, input logic st);
    if (w == 2) if2.start_tx = st;
    else        if1.start_tx = st;
  endtask

  task automatic set_data(input int w, input logic [7:0] d, input logic [2:0] bc, input logic [2:0] br);
    if (w == 2) begin
      if2.send_data = d; if2.bit_count_sel = bc; if2.baud_rate_sel = br;
    end else begin
      if1.send_data = d; if1.bit_count_sel = bc; if1.baud_rate_sel = br;
    end
  endtask

  // Called at the negedge before the start edge T. Checks every cycle of the frame and
  // the completion cycle; returns at the negedge after the data_sent edge.
  task automatic expect_frame(input int w, input logic [7:0] d, input logic [2:0] bc,
                              input logic [2:0] br, input bit scramble, input bit rearm,
                              output logic [7:0] nd, output logic [2:0] nbc, output logic [2:0] nbr);
    int n, div, s, len;
    n   = exp_n(int'(bc));
    div = exp_div(int'(br));
    s   = (w == 2) ? 2 : 1;
    len = (1 + n + s) * div;
    nd  = d; nbc = bc; nbr = br;
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      check_eq($sformatf("u%0d tx[%0d]", w, j), 32'(o_tx(w)), 32'(exp_tx(d, n, div, j)));
      check_eq($sformatf("u%0d busy[%0d]", w, j), 32'(o_busy(w)), 32'd1);
      check_eq($sformatf("u%0d sent_early[%0d]", w, j), 32'(o_sent(w)), 32'd0);
      if (scramble && j == 2) begin
        nd  = 8'($urandom);
        nbc = 3'($urandom);
        nbr = (w == 2) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 7));
        set_data(w, nd, nbc, nbr);
      end
      if (rearm && j == 1) set_start(w, 1'b0);
      if (rearm && j == 2) set_start(w, 1'b1);
    end
    @(negedge clk);
    check_eq($sformatf("u%0d busy_end", w), 32'(o_busy(w)), 32'd0);
    check_eq($sformatf("u%0d sent_pulse", w), 32'(o_sent(w)), 32'd1);
    check_eq($sformatf("u%0d tx_end", w), 32'(o_tx(w)), 32'd1);
  endtask

  // Line must sit idle for the given number of cycles (start_tx held as is).
  task automatic idle_hold(input int w, input int cycles);
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      check_eq($sformatf("u%0d idle_busy", w), 32'(o_busy(w)), 32'd0);
      check_eq($sformatf("u%0d idle_tx", w), 32'(o_tx(w)), 32'd1);
      check_eq($sformatf("u%0d idle_sent", w), 32'(o_sent(w)), 32'd0);
    end
  endtask

  // One cycle low, then high again: the next edge starts a frame.
  task automatic retrigger(input int w);
    set_start(w, 1'b0);
    @(negedge clk);
    set_start(w, 1'b1);
  endtask

  logic [7:0] cd, nd;
  logic [2:0] cb, cr, nb, nr;
  bit         sc, ra;

  initial begin
    rst = 1'b1;
    set_start(1, 1'b0); set_start(2, 1'b0);
    set_data(1, 8'h00, 3'd3, 3'd0);
    set_data(2, 8'h00, 3'd3, 3'd4);
    repeat (3) @(negedge clk);
    for (int w = 1; w <= 2; w++) begin
      check_eq($sformatf("u%0d rst_tx", w), 32'(o_tx(w)), 32'd1);
      check_eq($sformatf("u%0d rst_busy", w), 32'(o_busy(w)), 32'd0);
      check_eq($sformatf("u%0d rst_sent", w), 32'(o_sent(w)), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Basic frame 0xA5, 8 bits, DIV=10, then hold start_tx high: no second frame.
    set_data(1, 8'hA5, 3'd3, 3'd0);
    set_start(1, 1'b1);
    expect_frame(1, 8'hA5, 3'd3, 3'd0, 1'b0, 1'b0, nd, nb, nr);
    idle_hold(1, 500);

    // 5 data bits, then bit_count_sel=6 behaves as 8.
    set_data(1, 8'hFF, 3'd0, 3'd0);
    retrigger(1);
    expect_frame(1, 8'hFF, 3'd0, 3'd0, 1'b0, 1'b0, nd, nb, nr);
    set_data(1, 8'h3C, 3'd6, 3'd0);
    retrigger(1);
    expect_frame(1, 8'h3C, 3'd6, 3'd0, 1'b0, 1'b0, nd, nb, nr);

    // Inputs changed mid-frame: this frame keeps latched values, the next uses new ones.
    set_data(1, 8'h5A, 3'd3, 3'd1);
    retrigger(1);
    expect_frame(1, 8'h5A, 3'd3, 3'd1, 1'b1, 1'b0, nd, nb, nr);
    idle_hold(1, 5);
    retrigger(1);
    expect_frame(1, nd, nb, nr, 1'b0, 1'b0, nd, nb, nr);

    // Randomized frames, some back-to-back, some with inputs changed in flight.
    cd = 8'($urandom); cb = 3'($urandom); cr = 3'($urandom_range(0, 7));
    set_data(1, cd, cb, cr);
    retrigger(1);
    ra = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sc = 1'($urandom_range(0, 1));
      ra = (i == 15) ? 1'b0 : 1'($urandom_range(0, 1));
      expect_frame(1, cd, cb, cr, sc, ra, nd, nb, nr);
      cd = nd; cb = nb; cr = nr;
      if (!ra && i != 15) begin
        idle_hold(1, int'($urandom_range(1, 20)));
        retrigger(1);
      end
    end
    idle_hold(1, 3);

    // Reset during data bit 3 aborts at once; held start_tx must not restart after release.
    set_data(1, 8'hC3, 3'd3, 3'd0);
    retrigger(1);
    for (int j = 0; j <= 45; j++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_tx", 32'(o_tx(1)), 32'd1);
    check_eq("rst_async_busy", 32'(o_busy(1)), 32'd0);
    check_eq("rst_async_sent", 32'(o_sent(1)), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold_sent", 32'(o_sent(1)), 32'd0);
    end
    rst = 1'b0;
    idle_hold(1, 30);
    retrigger(1);
    expect_frame(1, 8'hC3, 3'd3, 3'd0, 1'b0, 1'b0, nd, nb, nr);

    // Two stop bits at DIV=1: 11-cycle frames, back-to-back.
    cd = 8'($urandom); cb = 3'd3; cr = 3'd4;
    set_data(2, cd, cb, cr);
    retrigger(2);
    for (int i = 0; i < 8; i++) begin
      sc = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      ra = (i != 7);
      expect_frame(2, cd, cb, cr, sc, ra, nd, nb, nr);
      cd = nd; cb = nb; cr = nr;
    end
    idle_hold(2, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
